sop_logic_array: RTL and testbench

- Parametrised, registered successor to the single-channel AND/OR/NOT glue circuit.
- Evaluates CH independent three-input logic channels (A, B, C) with a runtime-selectable function, debounces every input, and registers the outputs.
- Counts rising edges of each channel's primary output in saturating counters that are read back through a channel-select mux.
- Sits between the tile's dedicated input pins and its output pins; the top-level wrapper maps pins onto its buses.

---
 rtl/sop_logic_array.sv | 147 ++++++++++++++
 tb/tb_sop_logic_array.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_logic_array.sv
`default_nettype none
// ============================================================================
// Module      : sop_logic_array
// Description : CH-channel three-input logic array. Every input bit is
//               debounced, the channel function is runtime-selectable, the
//               outputs are registered, and rising edges of each primary
//               output are tallied in saturating counters with a select mux.
// Revision    : 1.0 - initial release
// ============================================================================
module sop_logic_array #(
    parameter int CH            = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8,
    localparam int c_sel_w      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CH-1:0]      a,
    input  logic [CH-1:0]      b,
    input  logic [CH-1:0]      c,
    input  logic [1:0]         mode,
    output logic [CH-1:0]      x,
    output logic [CH-1:0]      y,
    input  logic               cnt_clr,
    input  logic [c_sel_w-1:0] cnt_sel,
    output logic [CNT_W-1:0]   cnt_out,
    output logic               cnt_sat
);

    // Filters are laid out as {C bits, B bits, A bits}, CH bits per group.
    localparam int               c_nf      = 3 * CH;
    localparam int               c_kw      = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_kw-1:0]  c_k_last  = c_kw'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [c_nf-1:0]            s_q, s_d;
    logic [c_nf-1:0]            f_q, f_d;
    logic [c_nf-1:0][c_kw-1:0]  k_q, k_d;
    logic [1:0]                 mode_q, mode_d;
    logic [CH-1:0]              x_q, x_d;
    logic [CH-1:0]              y_q, y_d;
    logic                       primed_q, primed_d;
    logic [CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;

    logic [CH-1:0]              fa, fb, fc;
    logic [CH-1:0]              next_x;

    assign fa = f_q[CH-1:0];
    assign fb = f_q[2*CH-1:CH];
    assign fc = f_q[3*CH-1:2*CH];
    assign x  = x_q;
    assign y  = y_q;

    // Input sampling and per-bit debounce: f follows s only after s has
    // disagreed with f for STABLE_CYCLES consecutive enabled cycles.
    always_comb begin
        s_d    = s_q;
        f_d    = f_q;
        k_d    = k_q;
        mode_d = mode_q;
        if (en) begin
            s_d    = {c, b, a};
            mode_d = mode;
            for (int i = 0; i < c_nf; i++) begin
                if (s_q[i] == f_q[i]) begin
                    k_d[i] = '0;
                end else if (k_q[i] == c_k_last) begin
                    f_d[i] = s_q[i];
                    k_d[i] = '0;
                end else begin
                    k_d[i] = k_q[i] + 1'b1;
                end
            end
        end
    end

    // Channel function selected by the registered mode.
    always_comb begin
        next_x = '0;
        case (mode_q)
            2'd0:    next_x = (fa & fb) | ~fc;
            2'd1:    next_x = (fa | fb) & ~fc;
            2'd2:    next_x = fa ^ fb ^ fc;
            default: next_x = ~((fa & fb) | fc);
        endcase
    end

    // Output registers and saturating rising-edge counters; clear wins over
    // a coincident edge and works even while disabled.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        primed_d = primed_q;
        cnt_d    = cnt_q;
        if (en) begin
            x_d      = next_x;
            y_d      = ~fc;
            primed_d = 1'b1;
        end
        for (int i = 0; i < CH; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (en && primed_q && next_x[i] && !x_q[i] &&
                         (cnt_q[i] != c_cnt_max)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q      <= '0;
            f_q      <= '0;
            k_q      <= '0;
            mode_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s_q      <= s_d;
            f_q      <= f_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            x_q      <= x_d;
            y_q      <= y_d;
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
        end
    end

    // Counter readout; an out-of-range select reads as zero.
    always_comb begin
        cnt_out = '0;
        cnt_sat = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (cnt_sel == c_sel_w'(i)) begin
                cnt_out = cnt_q[i];
                cnt_sat = (cnt_q[i] == c_cnt_max);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sop_logic_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_sop_logic_array
// Description : Self-checking bench for sop_logic_array: directed sequences,
//               a mode/input truth table on one channel, and randomized
//               traffic compared against a history-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sop_logic_array;

    localparam int CH      = 4;
    localparam int STABLE  = 3;
    localparam int CNT_W   = 8;
    localparam int SEL_W   = 2;
    localparam int NF      = 3 * CH;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, en, cnt_clr;
    logic [CH-1:0]    a, b, c;
    logic [1:0]       mode;
    logic [SEL_W-1:0] cnt_sel;
    logic [CH-1:0]    x, y;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_sat;

    int checks   = 0;
    int failures = 0;

    sop_logic_array #(
        .CH            (CH),
        .STABLE_CYCLES (STABLE),
        .CNT_W         (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .a       (a),
        .b       (b),
        .c       (c),
        .mode    (mode),
        .x       (x),
        .y       (y),
        .cnt_clr (cnt_clr),
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out),
        .cnt_sat (cnt_sat)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each filter keeps the last STABLE enabled-cycle samples; it flips when
    // every one of them disagrees with its current filtered value.
    logic [NF-1:0] m_s, m_f;
    logic          hist [NF][STABLE];
    logic [1:0]    m_mode;
    logic [CH-1:0] m_x, m_y;
    int            m_cnt [CH];
    logic          m_primed;
    int            dut_cnt [CH];
    logic          dut_sat [CH];

    function automatic logic fx(input logic [1:0] md, input logic fa, input logic fb, input logic fc);
        case (md)
            2'd0:    return (fa & fb) | !fc;
            2'd1:    return (fa | fb) & !fc;
            2'd2:    return fa ^ fb ^ fc;
            default: return !((fa & fb) | fc);
        endcase
    endfunction

    task automatic model_step();
        logic [CH-1:0] nx, ny;
        bit all_diff;
        if (rst) begin
            m_s = '0; m_f = '0; m_mode = '0; m_x = '0; m_y = '0; m_primed = 1'b0;
            for (int i = 0; i < NF; i++)
                for (int j = 0; j < STABLE; j++) hist[i][j] = 1'b0;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                nx[i] = fx(m_mode, m_f[i], m_f[CH+i], m_f[2*CH+i]);
                ny[i] = !m_f[2*CH+i];
            end
            for (int i = 0; i < CH; i++) begin
                if (cnt_clr) m_cnt[i] = 0;
                else if (en && m_primed && nx[i] && !m_x[i] && m_cnt[i] < CNT_MAX)
                    m_cnt[i] = m_cnt[i] + 1;
            end
            if (en) begin
                for (int i = 0; i < NF; i++) begin
                    for (int j = STABLE - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                    hist[i][0] = m_s[i];
                    all_diff = 1'b1;
                    for (int j = 0; j < STABLE; j++)
                        if (hist[i][j] == m_f[i]) all_diff = 1'b0;
                    if (all_diff) m_f[i] = m_s[i];
                end
                m_x = nx;
                m_y = ny;
                m_s = {c, b, a};
                m_mode = mode;
                m_primed = 1'b1;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Model step, one clock edge, then compare all outputs 1ns after the edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model_x", 32'(x), 32'(m_x));
        check("model_y", 32'(y), 32'(m_y));
        for (int i = 0; i < CH; i++) begin
            cnt_sel = SEL_W'(i);
            #1;
            dut_cnt[i] = int'(cnt_out);
            dut_sat[i] = cnt_sat;
            check("model_cnt_out", 32'(cnt_out), 32'(m_cnt[i]));
            check("model_cnt_sat", 32'(cnt_sat), 32'(m_cnt[i] == CNT_MAX));
        end
    endtask

    // ---------------- truth table for channel 2 ----------------
    typedef struct {
        logic [1:0] md;
        logic       ia, ib, ic;
        logic       exp_x;
    } vec_t;
    vec_t tbl [32];

    initial begin
        logic [7:0] tt [4];
        int r;
        tt[0] = 8'hD5; tt[1] = 8'h54; tt[2] = 8'h96; tt[3] = 8'h15;
        for (int abc = 0; abc < 8; abc++) begin
            for (int m = 0; m < 4; m++) begin
                logic [2:0] v;
                logic [7:0] row;
                v   = 3'(abc);
                row = tt[m];
                r   = abc * 4 + m;
                tbl[r].md    = 2'(m);
                tbl[r].ia    = v[2];
                tbl[r].ib    = v[1];
                tbl[r].ic    = v[0];
                tbl[r].exp_x = row[abc];
            end
        end

        rst = 1'b1; en = 1'b1; cnt_clr = 1'b0;
        a = '0; b = '0; c = '0; mode = 2'd0; cnt_sel = '0;

        // Reset and first enabled evaluation.
        repeat (2) cycle();
        check("reset_x", 32'(x), 32'h0);
        check("reset_y", 32'(y), 32'h0);
        check("reset_cnt", 32'(dut_cnt[0]), 32'h0);
        rst = 1'b0;
        cycle();
        check("first_x", 32'(x), 32'hF);
        check("first_y", 32'(y), 32'hF);
        for (int i = 0; i < CH; i++) check("first_cnt", 32'(dut_cnt[i]), 32'h0);

        // Channel 0: c held high then low.
        c[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            if (i == 4) check("ch0_fall_early", 32'(x[0]), 32'h1);
            if (i == 5) check("ch0_fall", 32'(x[0]), 32'h0);
        end
        c[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            if (i == 4) check("ch0_rise_early", 32'(x[0]), 32'h0);
            if (i == 5) check("ch0_rise", 32'(x[0]), 32'h1);
        end
        check("ch0_cnt", 32'(dut_cnt[0]), 32'h1);

        // Two-cycle glitch on c[1] is filtered out.
        c[1] = 1'b1;
        repeat (2) cycle();
        c[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("glitch_x1", 32'(x[1]), 32'h1);
            check("glitch_y1", 32'(y[1]), 32'h1);
        end
        check("glitch_cnt1", 32'(dut_cnt[1]), 32'h0);

        // All modes over all input combinations on channel 2.
        for (int k = 0; k < 32; k++) begin
            if (k % 4 == 0) begin
                mode = 2'd0;
                a[2] = tbl[k].ia; b[2] = tbl[k].ib; c[2] = tbl[k].ic;
                repeat (5) cycle();
            end
            mode = tbl[k].md;
            repeat (2) cycle();
            check("table_x2", 32'(x[2]), 32'(tbl[k].exp_x));
        end

        // Saturation of channel 3 and clear coinciding with a rising edge.
        a = '0; b = '0; c = '0; mode = 2'd0;
        repeat (6) cycle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        for (int t = 0; t < 300; t++) begin
            c[3] = 1'b1;
            repeat (4) cycle();
            c[3] = 1'b0;
            repeat (4) cycle();
        end
        check("sat_cnt3", 32'(dut_cnt[3]), 32'd255);
        check("sat_flag3", 32'(dut_sat[3]), 32'h1);
        check("pre_edge_x3", 32'(x[3]), 32'h0);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("clr_edge_x3", 32'(x[3]), 32'h1);
        check("clr_edge_cnt3", 32'(dut_cnt[3]), 32'h0);
        check("clr_edge_sat3", 32'(dut_sat[3]), 32'h0);

        // Enable freeze while c changes, then full latency once re-enabled.
        repeat (6) cycle();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            c = CH'(i);
            cycle();
            check("freeze_x", 32'(x), 32'hF);
            check("freeze_y", 32'(y), 32'hF);
        end
        en = 1'b1;
        c = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            if (i == 4) check("unfreeze_x0_early", 32'(x[0]), 32'h1);
            if (i == 5) check("unfreeze_x0", 32'(x[0]), 32'h0);
        end

        // Reset in the middle of a debounce.
        c = 4'b0011;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        check("midrst_x", 32'(x), 32'h0);
        check("midrst_y", 32'(y), 32'h0);
        check("midrst_cnt0", 32'(dut_cnt[0]), 32'h0);
        check("midrst_sat0", 32'(dut_sat[0]), 32'h0);
        rst = 1'b0;
        c = '0;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            rst     = ($urandom_range(0, 199) == 0);
            cnt_clr = ($urandom_range(0, 63) == 0);
            a = a ^ CH'($urandom & $urandom);
            b = b ^ CH'($urandom & $urandom);
            c = c ^ CH'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
